apb_bus_arbiter: RTL and testbench

- Shares one APB requester local bus (BUS_ENA/BUS_WSTB/BUS_ADDR/BUS_WDATA in; BUS_READY/BUS_RDATA/BUS_SLVERR back) among NUM_REQ local masters.
- Fair round-robin arbitration, one transaction in flight at a time.
- Request fields are registered at grant; the response is routed back to the granted master only.
- Sits between on-chip masters (CPU, DMA, debug) and the APB bridge.

---
 rtl/apb_arb_pkg.sv | 13 +
 rtl/rr_picker.sv | 29 ++
 rtl/apb_bus_arbiter.sv | 145 ++++++++++++++
 tb/tb_apb_bus_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types and limits for the APB bus arbiter slice.
// Holds the arbiter state encoding and the supported requester ceiling.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRAIN = 2'd2
    } arb_state_e;

    localparam int MAX_REQ = 8;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: finds the first set request at or after ptr.
// Used by the arbiter to choose the next master while idle.
module rr_picker #(
    parameter  int NUM_REQ = 4,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic               valid,
    output logic [IDW-1:0]     idx
);

    logic [IDW-1:0] cand;

    // Walk offsets from the far end back to zero so the closest hit to ptr wins last.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = IDW'((int'(ptr) + k) % NUM_REQ);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/apb_bus_arbiter.sv
// Round-robin arbiter sharing one APB requester bus among NUM_REQ local masters.
// One transaction in flight; request fields captured at grant, response routed to the winner.
module apb_bus_arbiter
    import apb_arb_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int ADDR_WIDTH = 32,
    parameter  int DATA_WIDTH = 32,
    localparam int IDW        = $clog2(NUM_REQ),
    localparam int STBW       = DATA_WIDTH / 8
) (
    input  logic                          PCLK,
    input  logic                          PRESETn,
    input  logic [NUM_REQ-1:0]            REQ_ENA,
    input  logic [NUM_REQ*STBW-1:0]       REQ_WSTB,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_WDATA,
    output logic [NUM_REQ-1:0]            REQ_READY,
    output logic [NUM_REQ*DATA_WIDTH-1:0] REQ_RDATA,
    output logic [NUM_REQ-1:0]            REQ_SLVERR,
    output logic                          BUS_ENA,
    output logic [STBW-1:0]               BUS_WSTB,
    output logic [ADDR_WIDTH-1:0]         BUS_ADDR,
    output logic [DATA_WIDTH-1:0]         BUS_WDATA,
    input  logic                          BUS_READY,
    input  logic [DATA_WIDTH-1:0]         BUS_RDATA,
    input  logic                          BUS_SLVERR,
    output logic [IDW-1:0]                GRANT_ID,
    output logic                          ARB_BUSY
);

    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
        $error("apb_bus_arbiter: NUM_REQ out of range");
    end

    arb_state_e                    state_q, state_d;
    logic [IDW-1:0]                ptr_q, ptr_d;
    logic [IDW-1:0]                gnt_q, gnt_d;
    logic                          busy_q, busy_d;
    logic                          bus_ena_q, bus_ena_d;
    logic [STBW-1:0]               bus_wstb_q, bus_wstb_d;
    logic [ADDR_WIDTH-1:0]         bus_addr_q, bus_addr_d;
    logic [DATA_WIDTH-1:0]         bus_wdata_q, bus_wdata_d;
    logic [NUM_REQ-1:0]            req_ready_q, req_ready_d;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_rdata_q, req_rdata_d;
    logic [NUM_REQ-1:0]            req_slverr_q, req_slverr_d;

    logic                          pick_valid;
    logic [IDW-1:0]                pick_idx;

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req   (REQ_ENA),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gnt_d        = gnt_q;
        bus_ena_d    = bus_ena_q;
        bus_wstb_d   = bus_wstb_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        req_ready_d  = '0;
        req_rdata_d  = req_rdata_q;
        req_slverr_d = req_slverr_q;

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    bus_wstb_d  = REQ_WSTB[int'(pick_idx)*STBW +: STBW];
                    bus_addr_d  = REQ_ADDR[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                    bus_wdata_d = REQ_WDATA[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
                    bus_ena_d   = 1'b1;
                    gnt_d       = pick_idx;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                // Completion is decided by the bridge alone; the master's REQ_ENA is not consulted.
                if (BUS_READY) begin
                    req_ready_d[gnt_q]                                  = 1'b1;
                    req_rdata_d[int'(gnt_q)*DATA_WIDTH +: DATA_WIDTH] = BUS_RDATA;
                    req_slverr_d[gnt_q]                                 = BUS_SLVERR;
                    bus_ena_d = 1'b0;
                    ptr_d     = (gnt_q == IDW'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
                    state_d   = DRAIN;
                end
            end
            DRAIN: begin
                if (!BUS_READY) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            gnt_q        <= '0;
            busy_q       <= 1'b0;
            bus_ena_q    <= 1'b0;
            bus_wstb_q   <= '0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            req_ready_q  <= '0;
            req_rdata_q  <= '0;
            req_slverr_q <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            gnt_q        <= gnt_d;
            busy_q       <= busy_d;
            bus_ena_q    <= bus_ena_d;
            bus_wstb_q   <= bus_wstb_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            req_ready_q  <= req_ready_d;
            req_rdata_q  <= req_rdata_d;
            req_slverr_q <= req_slverr_d;
        end
    end

    assign REQ_READY  = req_ready_q;
    assign REQ_RDATA  = req_rdata_q;
    assign REQ_SLVERR = req_slverr_q;
    assign BUS_ENA    = bus_ena_q;
    assign BUS_WSTB   = bus_wstb_q;
    assign BUS_ADDR   = bus_addr_q;
    assign BUS_WDATA  = bus_wdata_q;
    assign GRANT_ID   = gnt_q;
    assign ARB_BUSY   = busy_q;

endmodule

// File: tb/tb_apb_bus_arbiter.sv
// Directed self-checking bench for apb_bus_arbiter with four masters and a hand-driven bridge.
// Expected values are hand-computed constants for each step of each scenario.
module tb_apb_bus_arbiter;

    localparam int NUM_REQ = 4;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int SW      = DW / 8;

    logic                  PCLK;
    logic                  PRESETn;
    logic [NUM_REQ-1:0]    REQ_ENA;
    logic [NUM_REQ*SW-1:0] REQ_WSTB;
    logic [NUM_REQ*AW-1:0] REQ_ADDR;
    logic [NUM_REQ*DW-1:0] REQ_WDATA;
    logic [NUM_REQ-1:0]    REQ_READY;
    logic [NUM_REQ*DW-1:0] REQ_RDATA;
    logic [NUM_REQ-1:0]    REQ_SLVERR;
    logic                  BUS_ENA;
    logic [SW-1:0]         BUS_WSTB;
    logic [AW-1:0]         BUS_ADDR;
    logic [DW-1:0]         BUS_WDATA;
    logic                  BUS_READY;
    logic [DW-1:0]         BUS_RDATA;
    logic                  BUS_SLVERR;
    logic [1:0]            GRANT_ID;
    logic                  ARB_BUSY;

    int vectors     = 0;
    int miscompares = 0;

    apb_bus_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .REQ_ENA    (REQ_ENA),
        .REQ_WSTB   (REQ_WSTB),
        .REQ_ADDR   (REQ_ADDR),
        .REQ_WDATA  (REQ_WDATA),
        .REQ_READY  (REQ_READY),
        .REQ_RDATA  (REQ_RDATA),
        .REQ_SLVERR (REQ_SLVERR),
        .BUS_ENA    (BUS_ENA),
        .BUS_WSTB   (BUS_WSTB),
        .BUS_ADDR   (BUS_ADDR),
        .BUS_WDATA  (BUS_WDATA),
        .BUS_READY  (BUS_READY),
        .BUS_RDATA  (BUS_RDATA),
        .BUS_SLVERR (BUS_SLVERR),
        .GRANT_ID   (GRANT_ID),
        .ARB_BUSY   (ARB_BUSY)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Watchdog so a wedged run still reports and terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic ena, input logic [SW-1:0] wstb,
                                 input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        REQ_ENA[idx]             = ena;
        REQ_WSTB[idx*SW +: SW]   = wstb;
        REQ_ADDR[idx*AW +: AW]   = addr;
        REQ_WDATA[idx*DW +: DW]  = wdata;
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Serve one granted transfer in the all-requesting round-robin scenario.
    task automatic serveGrant(input int g);
        checkOutput("rr_grant_id", 64'(GRANT_ID), 64'(g));
        checkOutput("rr_bus_addr", 64'(BUS_ADDR), 64'(32'h100 * g + 32'h4));
        checkOutput("rr_bus_ena", 64'(BUS_ENA), 64'd1);
        BUS_READY = 1'b1;
        tick();
        checkOutput("rr_pulse", 64'(REQ_READY), 64'(4'b0001 << g));
        BUS_READY = 1'b0;
        tick();
        checkOutput("rr_idle_busy", 64'(ARB_BUSY), 64'd0);
        tick();
    endtask

    initial begin
        PRESETn    = 1'b0;
        REQ_ENA    = '0;
        REQ_WSTB   = '0;
        REQ_ADDR   = '0;
        REQ_WDATA  = '0;
        BUS_READY  = 1'b0;
        BUS_RDATA  = '0;
        BUS_SLVERR = 1'b0;

        // Reset state
        repeat (2) @(posedge PCLK);
        #1;
        checkOutput("rst_bus_ena", 64'(BUS_ENA), 64'd0);
        checkOutput("rst_grant_id", 64'(GRANT_ID), 64'd0);
        checkOutput("rst_busy", 64'(ARB_BUSY), 64'd0);
        checkOutput("rst_req_ready", 64'(REQ_READY), 64'd0);
        PRESETn = 1'b1;
        tick();
        checkOutput("post_rst_bus_ena", 64'(BUS_ENA), 64'd0);

        // Single read from master 1
        applyStimulus(1, 1'b1, 4'h0, 32'h40, 32'h0);
        tick();
        checkOutput("rd_bus_ena", 64'(BUS_ENA), 64'd1);
        checkOutput("rd_bus_addr", 64'(BUS_ADDR), 64'h40);
        checkOutput("rd_bus_wstb", 64'(BUS_WSTB), 64'h0);
        checkOutput("rd_grant_id", 64'(GRANT_ID), 64'd1);
        checkOutput("rd_busy", 64'(ARB_BUSY), 64'd1);
        BUS_READY = 1'b1;
        BUS_RDATA = 32'hDEADBEEF;
        tick();
        checkOutput("rd_pulse", 64'(REQ_READY), 64'b0010);
        checkOutput("rd_rdata1", 64'(REQ_RDATA[DW*1 +: DW]), 64'hDEADBEEF);
        checkOutput("rd_bus_ena_off", 64'(BUS_ENA), 64'd0);
        applyStimulus(1, 1'b0, 4'h0, 32'h40, 32'h0);
        BUS_READY = 1'b0;
        tick();
        checkOutput("rd_pulse_end", 64'(REQ_READY), 64'd0);
        checkOutput("rd_idle_busy", 64'(ARB_BUSY), 64'd0);

        // Write with slave error from master 2
        applyStimulus(2, 1'b1, 4'hF, 32'h80, 32'h12345678);
        tick();
        checkOutput("wr_grant_id", 64'(GRANT_ID), 64'd2);
        checkOutput("wr_bus_wdata", 64'(BUS_WDATA), 64'h12345678);
        checkOutput("wr_bus_wstb", 64'(BUS_WSTB), 64'hF);
        BUS_READY  = 1'b1;
        BUS_SLVERR = 1'b1;
        BUS_RDATA  = 32'hAAAA5555;
        tick();
        checkOutput("wr_pulse", 64'(REQ_READY), 64'b0100);
        checkOutput("wr_slverr", 64'(REQ_SLVERR), 64'b0100);
        checkOutput("wr_rdata2", 64'(REQ_RDATA[DW*2 +: DW]), 64'hAAAA5555);
        checkOutput("wr_rdata1_held", 64'(REQ_RDATA[DW*1 +: DW]), 64'hDEADBEEF);
        applyStimulus(2, 1'b0, 4'h0, 32'h0, 32'h0);
        BUS_READY  = 1'b0;
        BUS_SLVERR = 1'b0;
        tick();

        // Stretched READY on master 0, which keeps requesting
        applyStimulus(0, 1'b1, 4'h0, 32'h0C, 32'h0);
        tick();
        checkOutput("st_grant_id", 64'(GRANT_ID), 64'd0);
        checkOutput("st_bus_ena", 64'(BUS_ENA), 64'd1);
        BUS_READY = 1'b1;
        BUS_RDATA = 32'h0000C0DE;
        tick();
        checkOutput("st_pulse", 64'(REQ_READY), 64'b0001);
        checkOutput("st_rdata0", 64'(REQ_RDATA[DW*0 +: DW]), 64'hC0DE);
        for (int c = 0; c < 2; c++) begin
            tick();
            checkOutput("st_no_repulse", 64'(REQ_READY), 64'd0);
            checkOutput("st_no_bus_ena", 64'(BUS_ENA), 64'd0);
            checkOutput("st_drain_busy", 64'(ARB_BUSY), 64'd1);
        end
        applyStimulus(0, 1'b1, 4'h0, 32'h10, 32'h0);
        BUS_READY = 1'b0;
        tick();
        checkOutput("st_back_idle", 64'(ARB_BUSY), 64'd0);
        checkOutput("st_idle_bus_ena", 64'(BUS_ENA), 64'd0);
        tick();
        checkOutput("st_regrant", 64'(BUS_ENA), 64'd1);
        checkOutput("st_regrant_addr", 64'(BUS_ADDR), 64'h10);

        // Input change and early REQ_ENA drop while granted
        applyStimulus(0, 1'b0, 4'h0, 32'h20, 32'h0);
        tick();
        checkOutput("chg_addr_hold1", 64'(BUS_ADDR), 64'h10);
        checkOutput("chg_ena_hold", 64'(BUS_ENA), 64'd1);
        tick();
        checkOutput("chg_addr_hold2", 64'(BUS_ADDR), 64'h10);
        BUS_READY = 1'b1;
        tick();
        checkOutput("chg_pulse", 64'(REQ_READY), 64'b0001);
        checkOutput("chg_addr_done", 64'(BUS_ADDR), 64'h10);
        BUS_READY = 1'b0;
        tick();

        // Reset in the middle of a grant to master 3
        applyStimulus(3, 1'b1, 4'h0, 32'h300, 32'h0);
        tick();
        checkOutput("mr_grant_id", 64'(GRANT_ID), 64'd3);
        checkOutput("mr_bus_ena", 64'(BUS_ENA), 64'd1);
        #2;
        PRESETn   = 1'b0;
        BUS_READY = 1'b1;
        #1;
        checkOutput("mr_async_bus_ena", 64'(BUS_ENA), 64'd0);
        checkOutput("mr_async_grant_id", 64'(GRANT_ID), 64'd0);
        checkOutput("mr_async_busy", 64'(ARB_BUSY), 64'd0);
        checkOutput("mr_async_addr", 64'(BUS_ADDR), 64'd0);
        checkOutput("mr_async_rdata1", 64'(REQ_RDATA[DW*1 +: DW]), 64'd0);
        checkOutput("mr_async_slverr", 64'(REQ_SLVERR), 64'd0);
        tick();
        checkOutput("mr_no_pulse", 64'(REQ_READY), 64'd0);
        applyStimulus(3, 1'b0, 4'h0, 32'h0, 32'h0);
        BUS_READY = 1'b0;
        PRESETn   = 1'b1;
        tick();
        checkOutput("mr_after_no_pulse", 64'(REQ_READY), 64'd0);
        checkOutput("mr_after_bus_ena", 64'(BUS_ENA), 64'd0);

        // Round robin with all four masters held; pointer restarts at 0
        for (int i = 0; i < NUM_REQ; i++) begin
            applyStimulus(i, 1'b1, 4'h0, 32'h100 * i + 32'h4, 32'h0);
        end
        tick();
        serveGrant(0);
        serveGrant(1);
        serveGrant(2);
        serveGrant(3);
        checkOutput("rr_wrap_grant_id", 64'(GRANT_ID), 64'd0);
        checkOutput("rr_wrap_bus_addr", 64'(BUS_ADDR), 64'h4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
